// File: rtl/wave_reader.sv
// wave_reader: per-frame sweep of the sample RAM, turning each sample into a clamped screen row
// and streaming (x, y0, y1, blank) line segments to the renderer over valid/ready.
module wave_reader #(
  parameter int HORIZONTAL = 640,
  parameter int ADDR_W = 10
) (
  input  logic              ram_rd_clk,
  input  logic              rd_rst,
  input  logic              frame_start,
  input  logic [7:0]        v_shift,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] wave_rd_addr,
  input  logic [7:0]        wave_rd_data,
  output logic              ram_rd_over,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [ADDR_W-1:0] pt_x,
  output logic [7:0]        pt_y0,
  output logic [7:0]        pt_y1,
  output logic              pt_blank,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] x;
  logic [7:0] data_q, vs_q, prev_y, row;
  logic prev_blank, cur_blank, start, accept, last;
  logic signed [9:0] t;
  // 255 - d equals ~d for an 8-bit sample; the sum fits 10-bit signed without overflow
  assign t = $signed({2'b00, ~data_q}) + $signed({{2{vs_q[7]}}, vs_q});
  assign row = t[9] ? 8'd0 : (t[8] ? 8'd255 : t[7:0]);
  assign cur_blank = &data_q;
  assign start = (state == IDLE || state == DONE) && frame_start;
  assign last = x == ADDR_W'(HORIZONTAL - 1);
  assign pt_valid = state == EMIT;
  assign accept = pt_valid && pt_ready;
  assign ram_rd_en = state == ISSUE;
  // x only moves on accept or restart, so it already holds the last issued address
  assign wave_rd_addr = x;
  assign pt_x = x;
  assign pt_y1 = pt_valid ? row : 8'd0;
  assign pt_y0 = pt_valid ? ((x == '0) ? row : prev_y) : 8'd0;
  assign pt_blank = pt_valid && (cur_blank || (x != '0 && prev_blank));
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = frame_start ? ISSUE : state;
      ISSUE:      state_n = WAIT;
      WAIT:       state_n = EMIT;
      EMIT:       state_n = pt_ready ? (last ? DONE : ISSUE) : EMIT;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge ram_rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= IDLE;
      x <= '0;
      data_q <= 8'd0;
      vs_q <= 8'd0;
      prev_y <= 8'd0;
      prev_blank <= 1'b0;
      ram_rd_over <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      if (start) begin
        x <= '0;
        ram_rd_over <= 1'b0;
        busy <= 1'b1;
      end
      if (state == WAIT) begin
        data_q <= wave_rd_data;
        vs_q <= v_shift;
      end
      if (accept) begin
        prev_y <= row;
        prev_blank <= cur_blank;
        if (last) begin
          ram_rd_over <= 1'b1;
          busy <= 1'b0;
        end else begin
          x <= x + ADDR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_wave_reader.sv
// tb_wave_reader: directed frames against a registered store model; expected segments are queued
// at frame start and popped by a monitor on every accepted segment.
module tb_wave_reader;
  logic clk = 0, rst = 1, frame_start = 0, pt_ready = 1;
  logic ram_rd_en, ram_rd_over, pt_valid, pt_blank, busy;
  logic [7:0] v_shift = 0, rdata = 0, pt_y0, pt_y1;
  logic [9:0] addr, pt_x;
  int checks = 0, passed = 0, cyc = 0, mode = 0, cdat = 0, seg_cnt = 0;
  int t_issue = 0, t_over = 0, stall_cnt = 0, s_enc = 0;
  bit issue_seen = 0, over_q = 1, stall_en = 0;
  int q[$];
  int cap_y0[640], cap_y1[640], cap_b[640];

  wave_reader dut (
    .ram_rd_clk(clk), .rd_rst(rst), .frame_start(frame_start), .v_shift(v_shift),
    .ram_rd_en(ram_rd_en), .wave_rd_addr(addr), .wave_rd_data(rdata), .ram_rd_over(ram_rd_over),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y0(pt_y0), .pt_y1(pt_y1),
    .pt_blank(pt_blank), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int store_fn(int a);
    return mode == 0 ? a % 256 : (mode == 1 ? cdat : (a == 10 ? 255 : 100));
  endfunction

  function automatic int row(int d, int vs);
    int t = 255 - d + vs;
    return t < 0 ? 0 : (t > 255 ? 255 : t);
  endfunction

  function automatic int enc(int x, int y0, int y1, int b);
    return (x << 17) | (y0 << 9) | (y1 << 1) | b;
  endfunction

  // one-cycle-latency store
  always @(posedge clk) if (ram_rd_en) rdata <= 8'(store_fn(int'(addr)));

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a == e) passed++;
    else $display("FAIL %s actual=%0d required=%0d", n, a, e);
  endtask

  always @(negedge clk) begin
    int e;
    e = enc(int'(pt_x), int'(pt_y0), int'(pt_y1), int'(pt_blank));
    if (stall_en && pt_valid && pt_x == 3 && stall_cnt < 7) begin
      pt_ready = 0;
      if (stall_cnt == 0) s_enc = e;
      else chk("stall_hold", e, s_enc);
      chk("stall_no_rd", int'(ram_rd_en), 0);
      stall_cnt++;
    end else pt_ready = 1;
    if (pt_valid && pt_ready) begin
      seg_cnt++;
      if (pt_x < 640) begin
        cap_y0[pt_x] = int'(pt_y0);
        cap_y1[pt_x] = int'(pt_y1);
        cap_b[pt_x] = int'(pt_blank);
      end
      if (q.size() == 0) chk("seg_extra", e, -1);
      else chk("seg", e, q.pop_front());
    end
    if (ram_rd_en && !issue_seen) begin
      issue_seen = 1;
      t_issue = cyc;
    end
    if (ram_rd_over && !over_q) t_over = cyc;
    over_q = ram_rd_over;
  end

  task automatic start_frame(input int m, input int c, input int vs);
    int py = 0, pb = 0;
    mode = m;
    cdat = c;
    v_shift = 8'(vs);
    for (int i = 0; i < 640; i++) begin
      int d = store_fn(i), y = row(d, vs), b = (d == 255) ? 1 : 0;
      q.push_back(enc(i, i == 0 ? y : py, y, (b != 0 || (i != 0 && pb != 0)) ? 1 : 0));
      py = y;
      pb = b;
    end
    seg_cnt = 0;
    issue_seen = 0;
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!ram_rd_over && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", int'(ram_rd_over), 1);
    @(negedge clk); @(negedge clk);
    chk("q_empty", q.size(), 0);
    chk("seg_count", seg_cnt, 640);
  endtask

  task automatic wait_x(input int v);
    int n = 0;
    while (!(pt_valid && int'(pt_x) == v) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_x", int'(pt_x), v);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_over", int'(ram_rd_over), 1);
    chk("rst_valid", int'(pt_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(ram_rd_en), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_y1", int'(pt_y1), 0);
    rst = 0;
    start_frame(0, 0, 0);
    wait_done();
    chk("sweep_len", t_over - t_issue, 1920);
    chk("x5_y0", cap_y0[5], 251);
    chk("x5_y1", cap_y1[5], 250);
    chk("x0_y0", cap_y0[0], 255);
    chk("x0_y1", cap_y1[0], 255);
    chk("x5_blank", cap_b[5], 0);
    start_frame(1, 128, 100);
    wait_done();
    chk("vs100_y1", cap_y1[7], 227);
    start_frame(1, 128, 127);
    wait_done();
    chk("vs127_y1", cap_y1[7], 254);
    start_frame(1, 0, 10);
    wait_done();
    chk("clamp_hi", cap_y1[7], 255);
    start_frame(1, 250, -20);
    wait_done();
    chk("clamp_lo", cap_y1[7], 0);
    start_frame(2, 0, 0);
    wait_done();
    chk("blank9", cap_b[9], 0);
    chk("blank10", cap_b[10], 1);
    chk("blank11", cap_b[11], 1);
    chk("blank12", cap_b[12], 0);
    chk("x11_y0", cap_y0[11], 0);
    chk("x11_y1", cap_y1[11], 155);
    stall_en = 1;
    stall_cnt = 0;
    start_frame(0, 0, 0);
    wait_done();
    stall_en = 0;
    chk("stall_cycles", stall_cnt, 7);
    chk("stall_len", t_over - t_issue, 1927);
    start_frame(0, 0, 0);
    wait_x(100);
    frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    wait_done();
    start_frame(1, 128, 100);
    chk("restart_over", int'(ram_rd_over), 0);
    chk("restart_busy", int'(busy), 1);
    chk("restart_x", int'(pt_x), 0);
    wait_done();
    start_frame(0, 0, 0);
    wait_x(300);
    rst = 1;
    #1;
    chk("mid_rst_valid", int'(pt_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_over", int'(ram_rd_over), 1);
    chk("mid_rst_x", int'(pt_x), 0);
    q.delete();
    @(posedge clk); #1 rst = 0;
    start_frame(0, 0, 0);
    wait_done();
    chk("post_rst_len", t_over - t_issue, 1920);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wave_reader.md
Name: wave_reader

Overview:
- Read-side sweeper for the DSO sample RAM, running in the display read clock domain.
- On each frame request, walks horizontal sample addresses 0..HORIZONTAL-1 and issues reads to the capture/store block.
- Converts each 8-bit sample to a screen row with vertical offset and clamping, and streams (x, previous y, current y, blank) line segments to the pixel renderer over a valid/ready handshake.
- Signals sweep completion back to the store via ram_rd_over so the next capture can be armed.

Parameters:
- HORIZONTAL, 640, number of sample columns swept per frame (2..1023).
- ADDR_W, 10, width of wave_rd_addr and pt_x.

Ports:
- ram_rd_clk  in  1  read-domain clock; all logic on rising edge.
- rd_rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  single-cycle request to begin a sweep.
- v_shift  in  8  signed vertical offset in pixel rows (+ moves trace down).
- ram_rd_en  out  1  read strobe to store.
- wave_rd_addr  out  ADDR_W  sample address to store.
- wave_rd_data  in  8  sample returned by store; 255 = out of range.
- ram_rd_over  out  1  level; sweep complete, held until next accepted frame_start.
- pt_valid  out  1  segment valid.
- pt_ready  in  1  renderer accepts segment.
- pt_x  out  ADDR_W  column index.
- pt_y0  out  8  row of previous column (equals pt_y1 at x=0).
- pt_y1  out  8  row of current column.
- pt_blank  out  1  segment must not be drawn.
- busy  out  1  sweep in progress.

Behaviour:
- Reset values:
  - all outputs 0, except ram_rd_over = 1 (store may free-run capture before the first frame);
  - FSM in IDLE; internal x counter and previous-y register 0.
- FSM states: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE/DONE: frame_start = 1 -> ISSUE, x = 0, ram_rd_over <= 0, busy <= 1. frame_start in any other state is ignored.
- ISSUE (1 cycle): ram_rd_en = 1, wave_rd_addr = x -> WAIT.
- WAIT (1 cycle):
  - store read latency is one cycle; wave_rd_data is sampled at the end of WAIT;
  - the registered data is used in EMIT;
  - ram_rd_en = 0 -> EMIT.
- EMIT:
  - pt_valid = 1; pt_x, pt_y0, pt_y1, pt_blank stable while pt_valid && !pt_ready.
  - On pt_valid && pt_ready: previous-y <= pt_y1, previous-blank <= current blank.
  - If x == HORIZONTAL-1 -> DONE; otherwise x <= x+1 -> ISSUE.
- DONE: ram_rd_over = 1, busy = 0, pt_valid = 0. Stays in DONE until frame_start.
- wave_rd_addr holds its last value outside ISSUE.
- Row arithmetic, in 10-bit signed:
  - t = (255 - d) + sign_extend(v_shift);
  - pt_y1 = 0 if t < 0, 255 if t > 255, otherwise t[7:0].
- Blanking:
  - current sample blank when d == 255;
  - pt_blank = current blank OR (x != 0 AND previous blank).
  - Blank samples still update previous-y with their computed row.
- x = 0: pt_y0 = pt_y1; pt_blank = current blank only.
- Throughput: 3 cycles per column with pt_ready held high. A full sweep of 640 columns completes in 1920 cycles from ISSUE entry to DONE entry.
- Reset asserted mid-sweep: immediately returns to reset values.
  - pt_valid drops asynchronously; the renderer must tolerate an abandoned frame.
- v_shift may change mid-sweep and is applied per column, sampled in WAIT.

Test Plan:
- Reset, then frame_start; store returns d = addr[7:0], v_shift = 0, pt_ready = 1, HORIZONTAL = 640 -> 640 segments:
  - x = 5: y0 = 251, y1 = 250;
  - x = 0: y0 = y1 = 255;
  - ram_rd_over rises exactly 1920 cycles after ISSUE entry.
- Constant d = 128; v_shift = +100 -> y1 = 227. v_shift = +127 -> y1 = 254. d = 0 with v_shift = +10 -> y1 = 255 (clamp). d = 250 with v_shift = -20 -> y1 = 0 (clamp).
- Store returns 255 at x = 10 only -> pt_blank = 1 at x = 10 and x = 11, 0 elsewhere; x = 11 has y0 = 0.
- pt_ready held low 7 cycles at x = 3 -> pt_x/pt_y0/pt_y1 unchanged throughout, no new ram_rd_en until accept, sweep length grows by 7 cycles.
- Second frame_start pulse during sweep at x = 100 -> ignored, exactly 640 segments; frame_start in DONE restarts at x = 0 and clears ram_rd_over the next cycle.
- rd_rst pulsed at x = 300 -> pt_valid = 0, busy = 0, ram_rd_over = 1, FSM IDLE; next frame_start sweeps from x = 0.
